video_mode_ctrl: RTL



---
 rtl/video_mode_pkg.sv | 22 ++
 rtl/frame_classifier.sv | 94 +++++++++
 rtl/video_mode_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/video_mode_pkg.sv
// Shared encodings for the Dreamcast capture mode controller.
// Mode codes, FSM states and nominal raw timing constants.
package video_mode_pkg;

   localparam logic [1:0] MODE_480P = 2'd0;
   localparam logic [1:0] MODE_480I = 2'd1;
   localparam logic [1:0] MODE_240P = 2'd2;
   localparam logic [1:0] MODE_NONE = 2'd3;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2,
      LOST    = 2'd3
   } state_t;

   localparam int RAW_WIDTH         = 1716;
   localparam int LINES_480P        = 525;
   localparam int LINES_FIELD_SHORT = 262;
   localparam int LINES_FIELD_LONG  = 263;

endpackage

// File: rtl/frame_classifier.sv
// Sync edge detection, line length checking and per-frame
// line counting; emits a candidate mode at each vsync fall.
module frame_classifier
   import video_mode_pkg::*;
#(
   parameter int LINE_MIN = 1700,
   parameter int LINE_MAX = 1732
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       _hsync,
   input  logic       _vsync,
   output logic       frame_done,
   output logic       hsync_fall,
   output logic       sync_edge,
   output logic [1:0] candidate
);

   localparam logic [11:0] L_MIN  = 12'(LINE_MIN);
   localparam logic [11:0] L_MAX  = 12'(LINE_MAX);
   localparam logic [9:0]  N_FRM  = 10'(LINES_480P);
   localparam logic [9:0]  N_SHRT = 10'(LINES_FIELD_SHORT);
   localparam logic [9:0]  N_LONG = 10'(LINES_FIELD_LONG);

   logic       hs_q;
   logic       vs_q;
   logic       vsync_fall;
   logic [11:0] hclk;
   logic [9:0] line_cnt;
   logic [9:0] prev_lines;
   logic [9:0] lines_now;
   logic       bad_frame;
   logic       first_line;
   logic       line_bad;
   logic       bad_now;

   assign hsync_fall = hs_q & ~_hsync;
   assign vsync_fall = vs_q & ~_vsync;
   assign frame_done = vsync_fall;
   assign sync_edge  = hsync_fall | vsync_fall;

   assign line_bad = hsync_fall && !first_line &&
                     (hclk < L_MIN || hclk > L_MAX);
   assign bad_now  = bad_frame | line_bad;

   // a coincident hsync fall belongs to the frame being closed
   assign lines_now = (hsync_fall && line_cnt != 10'd1023) ?
                      line_cnt + 10'd1 : line_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         hclk       <= '0;
         line_cnt   <= '0;
         prev_lines <= '0;
         bad_frame  <= 1'b0;
         first_line <= 1'b1;
      end else begin
         hs_q <= _hsync;
         vs_q <= _vsync;
         if (hsync_fall)
            hclk <= '0;
         else if (hclk != 12'hfff)
            hclk <= hclk + 12'd1;
         if (vsync_fall) begin
            line_cnt   <= '0;
            prev_lines <= lines_now;
            bad_frame  <= 1'b0;
            first_line <= 1'b1;
         end else begin
            line_cnt  <= lines_now;
            bad_frame <= bad_now;
            if (hsync_fall)
               first_line <= 1'b0;
         end
      end
   end

   always_comb begin
      candidate = MODE_NONE;
      if (bad_now)
         candidate = MODE_NONE;
      else if (lines_now >= N_FRM - 10'd1 && lines_now <= N_FRM + 10'd1)
         candidate = MODE_480P;
      else if (lines_now == prev_lines &&
               (lines_now == N_SHRT || lines_now == N_LONG))
         candidate = MODE_240P;
      else if ((lines_now == N_SHRT && prev_lines == N_LONG) ||
               (lines_now == N_LONG && prev_lines == N_SHRT))
         candidate = MODE_480I;
   end

endmodule

// File: rtl/video_mode_ctrl.sv
// Capture mode sequencer: locks onto 480p/480i/240p, drives the
// capture mode controls and falls back to internal timing on loss.
module video_mode_ctrl
   import video_mode_pkg::*;
#(
   parameter int LOSS_TIMEOUT = 108_000_000,
   parameter int LOCK_FRAMES  = 3,
   parameter int LINE_MIN     = 1700,
   parameter int LINE_MAX     = 1732
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       _hsync,
   input  logic       _vsync,
   output logic [1:0] mode,
   output logic       locked,
   output logic       line_doubler,
   output logic       generate_timing,
   output logic       resync,
   output logic [1:0] state_dbg
);

   localparam int TW = $clog2(LOSS_TIMEOUT + 1);
   localparam int MW = $clog2(LOCK_FRAMES + 1);
   localparam logic [TW-1:0] TIMEOUT = TW'(LOSS_TIMEOUT);
   localparam logic [TW-1:0] T_ONE   = TW'(1);
   localparam logic [MW-1:0] LOCK_N  = MW'(LOCK_FRAMES);
   localparam logic [MW-1:0] M_ONE   = MW'(1);

   logic          frame_done;
   logic          hsync_fall;
   logic          sync_edge;
   logic [1:0]    candidate;

   state_t        state_q;
   state_t        state_d;
   logic [MW-1:0] match_q;
   logic [MW-1:0] match_d;
   logic [MW-1:0] match_inc;
   logic [MW-1:0] match_new;
   logic [1:0]    prev_q;
   logic [1:0]    prev_d;
   logic [1:0]    mode_d;
   logic          resync_d;
   logic [TW-1:0] timer;

   frame_classifier #(
      .LINE_MIN (LINE_MIN),
      .LINE_MAX (LINE_MAX)
   ) u_cls (
      .clock      (clock),
      .reset      (reset),
      ._hsync     (_hsync),
      ._vsync     (_vsync),
      .frame_done (frame_done),
      .hsync_fall (hsync_fall),
      .sync_edge  (sync_edge),
      .candidate  (candidate)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= SEARCH;
         match_q      <= '0;
         prev_q       <= MODE_NONE;
         mode         <= MODE_NONE;
         line_doubler <= 1'b0;
         resync       <= 1'b0;
         timer        <= '0;
      end else begin
         state_q      <= state_d;
         match_q      <= match_d;
         prev_q       <= prev_d;
         mode         <= mode_d;
         line_doubler <= (mode_d == MODE_480I) || (mode_d == MODE_240P);
         resync       <= resync_d;
         if (sync_edge)
            timer <= '0;
         else if (timer != TIMEOUT)
            timer <= timer + T_ONE;
      end
   end

   assign match_new = (candidate != MODE_NONE) ? M_ONE : '0;
   assign match_inc = (candidate != MODE_NONE && candidate == prev_q) ?
                      match_q + M_ONE : match_new;

   always_comb begin
      state_d  = state_q;
      match_d  = match_q;
      prev_d   = prev_q;
      mode_d   = mode;
      resync_d = 1'b0;
      unique case (state_q)
         SEARCH: if (frame_done) begin
            state_d = MEASURE;
            match_d = '0;
            prev_d  = MODE_NONE;
         end
         MEASURE: if (frame_done) begin
            match_d = match_inc;
            prev_d  = candidate;
            if (match_inc == LOCK_N) begin
               state_d  = LOCKED;
               mode_d   = candidate;
               resync_d = 1'b1;
            end
         end
         LOCKED: if (frame_done && candidate != mode) begin
            state_d = MEASURE;
            match_d = match_new;
            prev_d  = candidate;
         end
         LOST: if (hsync_fall)
            state_d = SEARCH;
      endcase
      // an edge arriving on the timeout cycle keeps the stream alive
      if (state_q != LOST && timer == TIMEOUT && !sync_edge) begin
         state_d  = LOST;
         resync_d = 1'b0;
      end
   end

   always_comb begin
      locked          = (state_q == LOCKED);
      generate_timing = (state_q == LOST);
      state_dbg       = state_q;
   end

endmodule
